// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the four-digit seven-segment scan driver.
// Holds the scan-phase and nibble/digit-index types, the digit count, the
// all-anodes-off pattern and the sub-phase encoding within one digit slot.
package seven_seg_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [3:0]  AN_ALL_OFF = 4'b1111;

  typedef logic [3:0] phase_t;      // {digit index, sub-phase}, counts down
  typedef logic [3:0] nibble_t;
  typedef logic [1:0] digit_idx_t;

  // Sub-phases of one digit slot, in the order the down-counter visits them.
  typedef enum logic [1:0] {
    SUB_LEAD = 2'b11,
    SUB_ON_A = 2'b10,
    SUB_ON_B = 2'b01,
    SUB_TAIL = 2'b00
  } subphase_e;

endpackage

// File: rtl/scan_prescaler.sv
// Scan-rate prescaler: free-running counter 0..PRESCALE-1 that asserts
// `tick` on the cycle the count equals PRESCALE-1.
// Ports: clk (rising edge), reset (sync, active-high), tick (out).
module scan_prescaler #(
  parameter int unsigned PRESCALE = 16
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit time-multiplexed scan driver feeding a 4-bit-to-7-segment
// decoder on a common-anode display. A 16-bit value is accepted over a
// valid/ready handshake into a pending buffer and promoted to the display
// register at the next frame boundary.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   value[15:0]       - digit 3 = [15:12] ... digit 0 = [3:0]
//   value_valid       - value offered
//   value_ready       - pending buffer empty
//   char[3:0]         - nibble of the scanned digit (to decoder)
//   an[3:0]           - active-low anodes, an[3] = digit 3
//   frame_done        - one-cycle pulse at each frame boundary
// Build option: define SCAN_BLANKING_EN to blank sub-phases 11 and 00 of
// every digit slot (dead time around digit changes).
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int unsigned PRESCALE = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        value_valid,
  output logic        value_ready,
  output logic [3:0]  char,
  output logic [3:0]  an,
  output logic        frame_done
);

  logic        tick;
  logic        boundary;
  logic        accept;

  phase_t      phase_q, phase_d;
  logic [15:0] pending_q, pending_d;
  logic        pending_full_q, pending_full_d;
  logic [15:0] display_q, display_d;
  nibble_t     char_q, char_d;
  logic [3:0]  an_q, an_d;
  logic        frame_done_q, frame_done_d;
  digit_idx_t  sel_d;
  logic [3:0]  an_sel_d;

  scan_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_comb begin
    boundary     = tick && (phase_q == '0);
    accept       = value_valid && !pending_full_q;
    phase_d      = tick ? phase_q - 4'd1 : phase_q;
    frame_done_d = boundary;

    // Accept cannot coincide with a drain: accept needs an empty buffer.
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    display_d      = display_q;
    if (boundary && pending_full_q) begin
      display_d      = pending_q;
      pending_full_d = 1'b0;
    end else if (accept) begin
      pending_d      = value;
      pending_full_d = 1'b1;
    end

    // Outputs are decoded from the next phase so they load on the same
    // edge as the phase register and never lag it.
    sel_d    = phase_d[3:2];
    an_sel_d = ~(4'b0001 << sel_d);
    an_d     = an_q;
    char_d   = char_q;
    if (tick) begin
`ifdef SCAN_BLANKING_EN
      case (subphase_e'(phase_d[1:0]))
        SUB_ON_A, SUB_ON_B: an_d = an_sel_d;
        default:            an_d = AN_ALL_OFF;
      endcase
`else
      an_d = an_sel_d;
`endif
      if (subphase_e'(phase_d[1:0]) == SUB_LEAD)
        char_d = 4'(display_d >> {sel_d, 2'b00});
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q        <= 4'hF;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      display_q      <= '0;
      char_q         <= '0;
      an_q           <= AN_ALL_OFF;
      frame_done_q   <= 1'b0;
    end else begin
      phase_q        <= phase_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      display_q      <= display_d;
      char_q         <= char_d;
      an_q           <= an_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign value_ready = !pending_full_q;
  assign char        = char_q;
  assign an          = an_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner with PRESCALE = 4 (64-cycle
// frame). A timeline model derives the expected phase from the count of
// cycles since reset and tracks the pending/display values by the
// handshake rules; a table pins the first displayed frame.
module tb_seven_seg_scanner;

  localparam int unsigned P     = 4;
  localparam int unsigned FRAME = 16 * P;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic        value_valid;
  logic        value_ready;
  logic [3:0]  char;
  logic [3:0]  an;
  logic        frame_done;

  int unsigned tests = 0;
  int unsigned fails = 0;

  // model state
  int unsigned n = 0;          // cycles since reset released
  logic [15:0] m_disp = '0;
  logic [15:0] m_pendv = '0;
  logic        m_pend = 1'b0;

  seven_seg_scanner #(.PRESCALE(P)) dut (
    .clk         (clk),
    .reset       (reset),
    .value       (value),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .char        (char),
    .an          (an),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at n=%0d: got %h, expected %h", name, n, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_an();
    int unsigned ph, d, sub;
    logic [3:0] on;
    if (n < P) return 4'b1111;
    ph  = (15 + 16 * 64 - n / P) % 16;
    d   = ph / 4;
    sub = ph % 4;
    on  = 4'b1111;
    on[d] = 1'b0;
`ifdef SCAN_BLANKING_EN
    if (sub == 3 || sub == 0) return 4'b1111;
`endif
    return on;
  endfunction

  function automatic logic [3:0] exp_char();
    int unsigned ph;
    logic [15:0] v;
    ph = (15 + 16 * 64 - n / P) % 16;
    v  = m_disp >> (4 * (ph / 4));
    return v[3:0];
  endfunction

  // One clock cycle: drive, check ready before the edge, update the model
  // on the edge, check all outputs on the falling edge.
  task automatic step(input logic rst, input logic vld, input logic [15:0] val);
    reset = rst; value_valid = vld; value = val;
    #1;
    chk("ready_pre", 16'(value_ready), 16'(!m_pend));
    @(posedge clk);
    if (rst) begin
      n = 0; m_disp = '0; m_pend = 1'b0;
    end else begin
      n++;
      if (n % FRAME == 0 && m_pend) begin
        m_disp = m_pendv; m_pend = 1'b0;
      end else if (vld && !m_pend) begin
        m_pendv = val; m_pend = 1'b1;
      end
    end
    @(negedge clk);
    chk("an",    16'(an),         16'(exp_an()));
    chk("char",  16'(char),       16'(exp_char()));
    chk("fdone", 16'(frame_done), 16'(!rst && n > 0 && n % FRAME == 0));
    chk("ready", 16'(value_ready), 16'(!m_pend));
  endtask

  typedef struct {
    int unsigned cyc;
    logic [3:0]  an;
    logic [3:0]  chr;
    logic        fd;
  } vec_t;

  vec_t tab[$];

  initial begin
    int unsigned ti;
    logic got_abcd;
    logic vld;
    logic [15:0] val;
    logic ready_before;

`ifdef SCAN_BLANKING_EN
    tab = '{'{64, 4'b1111, 4'h1, 1'b1}, '{67, 4'b1111, 4'h1, 1'b0},
           '{68, 4'b0111, 4'h1, 1'b0}, '{75, 4'b0111, 4'h1, 1'b0},
           '{76, 4'b1111, 4'h1, 1'b0}, '{80, 4'b1111, 4'h2, 1'b0},
           '{84, 4'b1011, 4'h2, 1'b0}, '{96, 4'b1111, 4'h3, 1'b0},
           '{100, 4'b1101, 4'h3, 1'b0}, '{116, 4'b1110, 4'h4, 1'b0},
           '{124, 4'b1111, 4'h4, 1'b0}};
`else
    tab = '{'{64, 4'b0111, 4'h1, 1'b1}, '{79, 4'b0111, 4'h1, 1'b0},
           '{80, 4'b1011, 4'h2, 1'b0}, '{96, 4'b1101, 4'h3, 1'b0},
           '{112, 4'b1110, 4'h4, 1'b0}, '{127, 4'b1110, 4'h4, 1'b0}};
`endif

    reset = 1'b1; value_valid = 1'b0; value = '0;
    @(negedge clk);

    // reset held 3 cycles
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0);
    chk("rst_an",    16'(an), 16'hF);
    chk("rst_char",  16'(char), 16'h0);
    chk("rst_ready", 16'(value_ready), 16'h1);
    chk("rst_fd",    16'(frame_done), 16'h0);

    // 1234 offered at cycle 10, ABCD held from 20 until accepted
    ti = 0;
    got_abcd = 1'b0;
    while (n < 130) begin
      vld = 1'b0; val = '0;
      if (n == 10) begin vld = 1'b1; val = 16'h1234; end
      if (n >= 20 && !got_abcd) begin vld = 1'b1; val = 16'hABCD; end
      ready_before = value_ready;
      step(1'b0, vld, val);
      if (vld && ready_before && val == 16'hABCD) got_abcd = 1'b1;
      if (n == 11) chk("ready_after_1234", 16'(value_ready), 16'h0);
      if (n == 63) chk("ready_held_full", 16'(value_ready), 16'h0);
      if (n == 64) chk("ready_after_drain", 16'(value_ready), 16'h1);
      if (n == 65) chk("abcd_taken", 16'(value_ready), 16'h0);
      if (n == 128) chk("abcd_shown", 16'(char), 16'hA);
      if (ti < tab.size() && n == tab[ti].cyc) begin
        chk("tab_an",   16'(an), 16'(tab[ti].an));
        chk("tab_char", 16'(char), 16'(tab[ti].chr));
        chk("tab_fd",   16'(frame_done), 16'(tab[ti].fd));
        ti++;
      end
    end
    chk("tab_all_hit", 16'(ti), 16'(tab.size()));

    // randomized traffic against the model
    for (int i = 0; i < 400; i++)
      step(1'b0, ($urandom_range(0, 3) == 0), 16'($urandom));

    // reset mid-frame with pending full and valid high
    for (int i = 0; i < 200 && !m_pend; i++) step(1'b0, 1'b1, 16'h7777);
    chk("pend_full_before_rst", 16'(value_ready), 16'h0);
    step(1'b1, 1'b1, 16'hBEEF);
    chk("mid_rst_an",    16'(an), 16'hF);
    chk("mid_rst_char",  16'(char), 16'h0);
    chk("mid_rst_ready", 16'(value_ready), 16'h1);
    chk("mid_rst_fd",    16'(frame_done), 16'h0);
    while (n < 70) begin
      step(1'b0, 1'b0, 16'h0);
      if (n == 64) begin
        chk("post_rst_fd",   16'(frame_done), 16'h1);
        chk("post_rst_char", 16'(char), 16'h0);
      end
    end

    // accept exactly on the boundary edge with pending empty
    step(1'b1, 1'b0, 16'h0);
    while (n < 63) step(1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b1, 16'h5A5A);
    chk("coinc_old_char", 16'(char), 16'h0);
    chk("coinc_pending",  16'(value_ready), 16'h0);
    while (n < 130) begin
      step(1'b0, 1'b0, 16'h0);
      if (n == 127) chk("coinc_not_yet", 16'(char), 16'h0);
      if (n == 128) chk("coinc_shown", 16'(char), 16'h5);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Four-digit time-multiplexed scan driver that sits directly upstream of the 4-bit-to-7-segment LED decoder. It accepts a 16-bit hex value over a valid/ready handshake and buffers it until the next scan-frame boundary. It then cycles through the four digits, presenting one nibble on `char` to the decoder while driving the matching active-low anode line. The decoder's 7-bit segment output and this block's `an` output together drive the board's common-anode display.

## Interface
- `PRESCALE`, default 16: clock cycles per scan phase; legal range ≥1.
- `clk`: in, 1, system clock; all state changes on its rising edge.
- `reset`: in, 1, synchronous, active-high.
- `value`: in, 16, digit 3 = `[15:12]` (leftmost) … digit 0 = `[3:0]`.
- `value_valid`: in, 1, `value` is offered.
- `value_ready`: out, 1, the pending buffer is empty and can accept a value.
- `char`: out, 4, nibble of the currently scanned digit; feeds the decoder's `char` input.
- `an`: out, 4, active-low anode enables; `an[3]` is digit 3.
- `frame_done`: out, 1, one-cycle pulse at each frame boundary.

## Operation
- Prescaler counts 0..PRESCALE-1 and wraps. `tick` is asserted on the cycle the count equals PRESCALE-1.
- Phase counter is 4 bits, reset value 15. It decrements by 1 on each `tick` and wraps 0→15.
- `phase[3:2]` selects the digit: 3 = digit 3 … 0 = digit 0.
- `phase[1:0]` controls the anode for that digit.
  - With blanking: `11` → all anodes off; `10`, `01` → selected anode low; `00` → all anodes off.
  - Without blanking: the selected anode is low for all four sub-phases.
- `char` = display register nibble selected by `phase[3:2]`. It changes only when the phase enters `xx11`, which is always a blanked sub-phase when blanking is enabled.
- Handshake:
  - A transfer occurs when `value_valid && value_ready`. The value is stored in the pending register, `pending_full` is set, and `value_ready` drops the next cycle.
  - `value_valid` may be held high across cycles. Only transfers count.
- Frame boundary is the `tick` cycle while phase = 0. On that edge:
  - phase → 15.
  - `frame_done` = 1 for one cycle.
  - If `pending_full`, the display register takes the pending value and `pending_full` clears.
- Accept coincident with a frame boundary (possible only when the pending register is empty): the new value goes to the pending register and is displayed at the following boundary.
- `reset` overrides everything, including an accept in the same cycle. Pending data is discarded.
- Reset values:
  - prescaler 0, phase 15.
  - display register 16'h0000, `pending_full` 0.
  - `value_ready` 1, `frame_done` 0.
  - `an` 4'b1111, `char` 4'h0.

## Timing
- `an`, `char` and `frame_done` are registers, loaded on the same edge the phase updates from the next-phase decode. They are never out of step with the phase counter.
- Frame length = 16 × PRESCALE cycles. Each digit's anode is on for 2 × PRESCALE cycles with blanking and 4 × PRESCALE cycles without.
- First `tick` occurs PRESCALE cycles after reset deasserts. The first boundary occurs 16 × PRESCALE cycles after reset deasserts.
- Accept-to-display latency is 1 to 16 × PRESCALE cycles (next boundary). In the coincident-boundary case it is one full frame more.
- `value_ready` returns to 1 the cycle after the boundary that drains the pending register.

## Configuration
- `SCAN_BLANKING_EN` defined: sub-phases `11` and `00` of every digit force `an` = 1111. This gives dead time around digit changes to suppress ghosting.
- `SCAN_BLANKING_EN` undefined: no blanking. The anode switches directly from one digit to the next on the `tick` edge into `xx11`; `char` changes on the same edge.

## Structure
- Shared package `seven_seg_pkg` holds:
  - phase typedef (4-bit)
  - `NUM_DIGITS` = 4
  - `AN_ALL_OFF` = 4'b1111
  - nibble/digit index typedefs
- Sub-module `scan_prescaler`: parameterised by PRESCALE, with `clk`, `reset` and `tick` out; counter width = clog2(PRESCALE), minimum 1 bit.
- Top level holds the phase counter, pending and display registers, handshake and output decode.

## Test plan
All scenarios use PRESCALE = 4, so frame = 64 cycles.
- Reset held 3 cycles → `an` = 1111, `char` = 0, `value_ready` = 1, `frame_done` = 0; first `frame_done` pulse 64 cycles after release.
- Offer 16'h1234 at cycle 10 → `value_ready` = 0 from cycle 11. After the cycle-64 boundary, with blanking:
  - `char` = 1, `an` = 1111 for 4 cycles, then 0111 for 8 cycles, then 1111 for 4 cycles.
  - Then `char` = 2, `an` = 1011 (same 4/8/4 pattern), and so on for digits 1 and 0.
- Hold `value_valid` with 16'hABCD while pending is full → no transfer until `value_ready` returns the cycle after the boundary. Then ABCD is accepted and shown from the next boundary.
- `SCAN_BLANKING_EN` undefined, value 16'h00F0 → `an` runs 0111, 1011, 1101, 1110, 16 cycles each; `char` = F during the 1101 window.
- Reset asserted mid-frame with pending full and `value_valid` high → next cycle all reset values; display stays 0 through the next boundary.
- Accept 16'h5A5A on the exact boundary cycle 64 with pending empty → digits still show the old value; 5A5A appears at the cycle-128 boundary.
